// File: rtl/pwm_expander_core.sv
// pwm_expander_core: SPI mode-0 slave (sampled in the CLK domain) driving a
// byte-addressed register file of PWM channels with read-back, burst access
// and period-boundary commits of period/duty.
// Ports:
//   CLK, RST        system clock, asynchronous active-high reset
//   _CS, SCLK, MOSI SPI slave inputs, asynchronous to CLK
//   MISO            SPI read data, MSB first, 0 outside read data bytes
//   PWMOutputs      one registered PWM pin per channel
module pwm_expander_core #(
  parameter int unsigned NumOfPWMOutputs = 4,
  parameter int unsigned CounterWidth    = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       _CS,
  input  logic                       SCLK,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic [NumOfPWMOutputs-1:0] PWMOutputs
);

  localparam int unsigned NumCh = NumOfPWMOutputs;
  localparam int unsigned CW    = CounterWidth;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  state_t state, state_n;

  logic [1:0] cs_sync, sclk_sync, mosi_sync;
  logic       cs_d, sclk_d;
  logic       cs_s, sclk_s, mosi_s;
  logic       cs_rise_c, sclk_rise_c, sclk_fall_c;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [6:0] addr;
  logic       rd_mode;
  logic [7:0] tx_shift;

  logic       byte_done_c, wr_en_c, load_tx_c;
  logic [7:0] rx_byte_c, rd_data_c;
  logic [6:0] rd_addr_c;
  logic [3:0] wr_ch, rd_ch;
  logic [2:0] wr_off, rd_off;

  logic [NumCh-1:0] en, inv, pend_wr, commit_pend;
  logic [CW-1:0]    period_sh [NumCh];
  logic [CW-1:0]    duty_sh   [NumCh];
  logic [CW-1:0]    period_a  [NumCh];
  logic [CW-1:0]    duty_a    [NumCh];
  logic [CW-1:0]    cnt       [NumCh];

  // Byte view of a counter-width register; the high byte is 0 when CW = 8.
  function automatic logic [7:0] get_byte(input logic [CW-1:0] v, input logic hi);
    logic [15:0] w;
    w = 16'(v);
    return hi ? w[15:8] : w[7:0];
  endfunction

  // Replace one byte; a high-byte write is truncated away when CW = 8.
  function automatic logic [CW-1:0] put_byte(input logic [CW-1:0] v, input logic [7:0] b,
                                             input logic hi);
    logic [15:0] w;
    w = 16'(v);
    if (hi) w[15:8] = b;
    else    w[7:0]  = b;
    return CW'(w);
  endfunction

  // Two-flop synchronisers plus one stage for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], _CS};
      sclk_sync <= {sclk_sync[0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
      cs_d      <= cs_sync[1];
      sclk_d    <= sclk_sync[1];
    end
  end

  assign cs_s        = cs_sync[1];
  assign sclk_s      = sclk_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign cs_rise_c   = cs_s & ~cs_d;
  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign sclk_fall_c = ~sclk_s & sclk_d;

  assign rx_byte_c   = {rx_shift, mosi_s};
  assign byte_done_c = (state != ST_IDLE) && !cs_s && sclk_rise_c && (bit_cnt == 3'd7);
  assign wr_en_c     = byte_done_c && (state == ST_DATA) && !rd_mode;
  // Command completion reads the start address; later bytes read the next one.
  assign rd_addr_c   = (state == ST_CMD) ? rx_byte_c[6:0] : addr + 7'd1;
  assign load_tx_c   = byte_done_c && ((state == ST_CMD) ? rx_byte_c[7] : rd_mode);
  assign wr_ch       = addr[6:3];
  assign wr_off      = addr[2:0];
  assign rd_ch       = rd_addr_c[6:3];
  assign rd_off      = rd_addr_c[2:0];
  assign MISO        = tx_shift[7];

  // Transaction phase register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Phase sequencing: disarmed until the first _CS rise, then command/data.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (cs_rise_c) state_n = ST_CMD;
      ST_CMD:  if (byte_done_c) state_n = ST_DATA;
      ST_DATA: if (cs_s) state_n = ST_CMD;
      default: state_n = ST_IDLE;
    endcase
  end

  // Bit framing, address tracking and the MISO shift register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      addr     <= 7'd0;
      rd_mode  <= 1'b0;
      tx_shift <= 8'd0;
    end else if (state == ST_IDLE || cs_s) begin
      bit_cnt  <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      if (sclk_rise_c) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte_c[6:0];
      end
      if (byte_done_c) begin
        if (state == ST_CMD) begin
          rd_mode <= rx_byte_c[7];
          addr    <= rx_byte_c[6:0];
        end else begin
          addr    <= addr + 7'd1;
        end
      end
      // No shift on the falling edge between bytes so bit 7 is presented first.
      if (load_tx_c)                           tx_shift <= rd_data_c;
      else if (sclk_fall_c && bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // Register read mux; unimplemented channels and reserved offsets read 0.
  always_comb begin
    rd_data_c = 8'd0;
    for (int unsigned n = 0; n < NumCh; n++) begin
      if (rd_ch == 4'(n)) begin
        case (rd_off)
          3'd0:    rd_data_c = {6'd0, inv[n], en[n]};
          3'd1:    rd_data_c = get_byte(period_sh[n], 1'b0);
          3'd2:    rd_data_c = get_byte(period_sh[n], 1'b1);
          3'd3:    rd_data_c = get_byte(duty_sh[n], 1'b0);
          3'd4:    rd_data_c = get_byte(duty_sh[n], 1'b1);
          default: rd_data_c = 8'd0;
        endcase
      end
    end
  end

  // Per-channel registers, shadow commit and PWM generation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en          <= '0;
      inv         <= '0;
      pend_wr     <= '0;
      commit_pend <= '0;
      PWMOutputs  <= '0;
      for (int unsigned n = 0; n < NumCh; n++) begin
        period_sh[n] <= '0;
        duty_sh[n]   <= '0;
        period_a[n]  <= '0;
        duty_a[n]    <= '0;
        cnt[n]       <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NumCh; n++) begin
        if (wr_en_c && wr_ch == 4'(n)) begin
          case (wr_off)
            3'd0: begin
              en[n]  <= rx_byte_c[0];
              inv[n] <= rx_byte_c[1];
            end
            3'd1:    period_sh[n] <= put_byte(period_sh[n], rx_byte_c, 1'b0);
            3'd2:    period_sh[n] <= put_byte(period_sh[n], rx_byte_c, 1'b1);
            3'd3:    duty_sh[n]   <= put_byte(duty_sh[n], rx_byte_c, 1'b0);
            3'd4:    duty_sh[n]   <= put_byte(duty_sh[n], rx_byte_c, 1'b1);
            default: ;
          endcase
          if (wr_off >= 3'd1 && wr_off <= 3'd4) pend_wr[n] <= 1'b1;
        end
        // Commit at the wrap when running, immediately when disabled.
        if (commit_pend[n] && (!en[n] || cnt[n] >= period_a[n])) begin
          period_a[n]    <= period_sh[n];
          duty_a[n]      <= duty_sh[n];
          commit_pend[n] <= 1'b0;
        end
        // Placed after the commit so a coinciding _CS rise re-arms the commit.
        if (cs_rise_c && pend_wr[n]) begin
          commit_pend[n] <= 1'b1;
          pend_wr[n]     <= 1'b0;
        end
        if (!en[n])                       cnt[n] <= '0;
        else if (cnt[n] >= period_a[n])   cnt[n] <= '0;
        else                              cnt[n] <= cnt[n] + CW'(1);
        PWMOutputs[n] <= en[n] & ((cnt[n] < duty_a[n]) ^ inv[n]);
      end
    end
  end

endmodule
